dac_jesd204_channel_src: RTL



---
 rtl/dac_jesd204_channel_src.sv | 119 +++++++++++
 1 files changed

// File: rtl/dac_jesd204_channel_src.sv
// Per-channel DAC sample source for the JESD204 transmit path: DMA, constant,
// PN7, PN15 or ramp beats, optionally offset-binary, truncated to CHANNEL_WIDTH.
module dac_jesd204_channel_src #(
  parameter int DATA_PATH_WIDTH = 4,
  parameter int CHANNEL_WIDTH   = 14,
  parameter int OCT_PER_SAMPLE  = 2
) (
  input  logic                                     dac_clk,
  input  logic                                     dac_rstn,
  input  logic                                     dac_enable,
  input  logic [3:0]                               dac_data_sel,
  input  logic                                     dac_dfmt_enable,
  input  logic [15:0]                              dac_const,
  input  logic [DATA_PATH_WIDTH*16-1:0]            dac_dma_data,
  input  logic                                     dac_dma_valid,
  output logic                                     dac_dma_ready,
  output logic                                     dac_underflow,
  output logic [DATA_PATH_WIDTH*CHANNEL_WIDTH-1:0] dac_if_data
);
  localparam int SW = 8 * OCT_PER_SAMPLE;
  localparam int NB = SW * DATA_PATH_WIDTH;
  localparam logic [3:0] SEL_DMA   = 4'd0;
  localparam logic [3:0] SEL_CONST = 4'd1;
  localparam logic [3:0] SEL_PN7   = 4'd2;
  localparam logic [3:0] SEL_PN15  = 4'd3;
  localparam logic [3:0] SEL_RAMP  = 4'd4;
  localparam logic [6:0]  PN7_SEED  = 7'h7F;
  localparam logic [14:0] PN15_SEED = 15'h7FFF;

  logic [3:0]  sel_reg;
  logic        enable_reg;
  logic [6:0]  pn7_reg, pn7_cur, pn7_adv;
  logic [14:0] pn15_reg, pn15_cur, pn15_adv;
  logic [15:0] ramp_reg, ramp_cur;
  logic [NB-1:0] pn7_bits, pn15_bits, fmt_beat;
  logic [DATA_PATH_WIDTH*CHANNEL_WIDTH-1:0] beat;
  logic reseed;
  logic unused_fmt;

  assign dac_dma_ready = dac_rstn & dac_enable & (dac_data_sel == SEL_DMA);

  // A new pattern starts in the very cycle the new select or enable is seen.
  assign reseed   = (dac_data_sel != sel_reg) | (dac_enable & ~enable_reg);
  assign pn7_cur  = reseed ? PN7_SEED  : pn7_reg;
  assign pn15_cur = reseed ? PN15_SEED : pn15_reg;
  assign ramp_cur = reseed ? 16'h0000  : ramp_reg;

  // Bit i of the generated stream lands in sample i/SW, first bit at the MSB.
  always_comb begin
    pn7_adv   = pn7_cur;
    pn15_adv  = pn15_cur;
    pn7_bits  = '0;
    pn15_bits = '0;
    for (int i = 0; i < NB; i++) begin
      pn7_bits[(i / SW) * SW + SW - 1 - (i % SW)]  = pn7_adv[6] ^ pn7_adv[5];
      pn15_bits[(i / SW) * SW + SW - 1 - (i % SW)] = pn15_adv[14] ^ pn15_adv[13];
      pn7_adv  = {pn7_adv[5:0], pn7_adv[6] ^ pn7_adv[5]};
      pn15_adv = {pn15_adv[13:0], pn15_adv[14] ^ pn15_adv[13]};
    end
  end

  for (genvar gi = 0; gi < DATA_PATH_WIDTH; gi++) begin : g_sample
    logic [SW-1:0] raw;
    logic          fmt_en;
    always_comb begin
      raw    = '0;
      fmt_en = 1'b0;
      case (dac_data_sel)
        SEL_DMA: begin
          raw    = dac_dma_valid ? dac_dma_data[SW*gi +: SW] : '0;
          fmt_en = dac_dma_valid;
        end
        SEL_CONST: begin
          raw    = dac_const;
          fmt_en = 1'b1;
        end
        SEL_PN7:  raw = pn7_bits[SW*gi +: SW];
        SEL_PN15: raw = pn15_bits[SW*gi +: SW];
        SEL_RAMP: begin
          raw    = ramp_cur + 16'(gi);
          fmt_en = 1'b1;
        end
        default: raw = '0;
      endcase
    end
    assign fmt_beat[SW*gi +: SW] = {raw[SW-1] ^ (fmt_en & dac_dfmt_enable), raw[SW-2:0]};
    assign beat[CHANNEL_WIDTH*gi +: CHANNEL_WIDTH] = fmt_beat[SW*gi + SW - 1 -: CHANNEL_WIDTH];
  end

  // Low bits dropped by truncation are intentionally discarded.
  assign unused_fmt = ^fmt_beat;

  always_ff @(posedge dac_clk or negedge dac_rstn) begin
    if (!dac_rstn) begin
      sel_reg       <= '0;
      enable_reg    <= 1'b0;
      pn7_reg       <= PN7_SEED;
      pn15_reg      <= PN15_SEED;
      ramp_reg      <= '0;
      dac_if_data   <= '0;
      dac_underflow <= 1'b0;
    end else begin
      sel_reg       <= dac_data_sel;
      enable_reg    <= dac_enable;
      dac_underflow <= dac_dma_ready & ~dac_dma_valid;
      if (dac_enable) begin
        dac_if_data <= beat;
        pn7_reg     <= (dac_data_sel == SEL_PN7)  ? pn7_adv  : pn7_cur;
        pn15_reg    <= (dac_data_sel == SEL_PN15) ? pn15_adv : pn15_cur;
        ramp_reg    <= ramp_cur + 16'(DATA_PATH_WIDTH);
      end else begin
        dac_if_data <= '0;
        pn7_reg     <= PN7_SEED;
        pn15_reg    <= PN15_SEED;
        ramp_reg    <= '0;
      end
    end
  end
endmodule
